i2c_slave_ram_arbiter: RTL

I2C_SLAVE_RAM_ARBITER -- requirements
Module: i2c_slave_ram_arbiter

---
 rtl/i2c_slave_ram_arbiter.sv | 175 +++++++++++++++++
 1 files changed

// File: rtl/i2c_slave_ram_arbiter.sv
// Arbitrates one single-port RAM between an I2C master reader, two writers
// (I2C master, menu controller) and a background clear sweep.
module i2c_slave_ram_arbiter #(
  parameter int                ADDR_W     = 5,
  parameter int                DATA_W     = 8,
  parameter logic [DATA_W-1:0] CLEAR_CHAR = 8'h20
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              rd_req,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic              rd_ack,
  output logic              rd_valid,
  output logic [DATA_W-1:0] rd_data,
  input  logic              mw_req,
  input  logic [ADDR_W-1:0] mw_addr,
  input  logic [DATA_W-1:0] mw_data,
  output logic              mw_ack,
  input  logic              uw_req,
  input  logic [ADDR_W-1:0] uw_addr,
  input  logic [DATA_W-1:0] uw_data,
  output logic              uw_ack,
  input  logic              clr_start,
  output logic              clr_busy,
  output logic              clr_done,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  output logic              ram_we,
  output logic              ram_re,
  input  logic [DATA_W-1:0] ram_rdata
);

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_CLEAR = 1'b1
  } state_t;

  state_t              state_q;
  logic [ADDR_W-1:0]   cnt_q;
  logic                rr_mw_last_q;
  logic                rd_ack_q, mw_ack_q, uw_ack_q;
  logic                rd_pend_q, rd_valid_q;
  logic [DATA_W-1:0]   rd_data_q;
  logic                ram_we_q, ram_re_q;
  logic [ADDR_W-1:0]   ram_addr_q;
  logic [DATA_W-1:0]   ram_wdata_q;
  logic                clr_busy_q, clr_done_q;

  logic                grant_rd_d, grant_mw_d, grant_uw_d, grant_clr_d;
  logic                mw_elig_d, uw_elig_d, last_clr_d;

  // Grant selection; a requester acked in the current cycle sits out this edge.
  always_comb begin
    grant_rd_d  = rd_req & ~rd_ack_q;
    mw_elig_d   = mw_req & ~mw_ack_q;
    uw_elig_d   = uw_req & ~uw_ack_q;
    grant_mw_d  = 1'b0;
    grant_uw_d  = 1'b0;
    if (grant_rd_d) begin
      grant_mw_d = 1'b0;
      grant_uw_d = 1'b0;
    end else if (mw_elig_d && uw_elig_d) begin
      grant_mw_d = ~rr_mw_last_q;
      grant_uw_d = rr_mw_last_q;
    end else begin
      grant_mw_d = mw_elig_d;
      grant_uw_d = uw_elig_d;
    end
    grant_clr_d = (state_q == ST_CLEAR) & ~grant_rd_d & ~grant_mw_d & ~grant_uw_d;
    last_clr_d  = grant_clr_d & (cnt_q == {ADDR_W{1'b1}});
  end

  // Registered RAM port, acks, read-return pipeline and the clear FSM.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      cnt_q        <= {ADDR_W{1'b0}};
      rr_mw_last_q <= 1'b0;
      rd_ack_q     <= 1'b0;
      mw_ack_q     <= 1'b0;
      uw_ack_q     <= 1'b0;
      rd_pend_q    <= 1'b0;
      rd_valid_q   <= 1'b0;
      rd_data_q    <= {DATA_W{1'b0}};
      ram_we_q     <= 1'b0;
      ram_re_q     <= 1'b0;
      ram_addr_q   <= {ADDR_W{1'b0}};
      ram_wdata_q  <= {DATA_W{1'b0}};
      clr_busy_q   <= 1'b0;
      clr_done_q   <= 1'b0;
    end else begin
      rd_ack_q <= grant_rd_d;
      mw_ack_q <= grant_mw_d;
      uw_ack_q <= grant_uw_d;
      ram_re_q <= grant_rd_d;
      ram_we_q <= grant_mw_d | grant_uw_d | grant_clr_d;

      if (grant_rd_d) begin
        ram_addr_q <= rd_addr;
      end else if (grant_mw_d) begin
        ram_addr_q  <= mw_addr;
        ram_wdata_q <= mw_data;
      end else if (grant_uw_d) begin
        ram_addr_q  <= uw_addr;
        ram_wdata_q <= uw_data;
      end else if (grant_clr_d) begin
        ram_addr_q  <= cnt_q;
        ram_wdata_q <= CLEAR_CHAR;
      end else begin
        ram_addr_q  <= ram_addr_q;
        ram_wdata_q <= ram_wdata_q;
      end

      if (grant_mw_d || grant_uw_d) begin
        rr_mw_last_q <= grant_mw_d;
      end else begin
        rr_mw_last_q <= rr_mw_last_q;
      end

      // RAM returns data one cycle after ram_re; capture it the cycle after that.
      rd_pend_q  <= ram_re_q;
      rd_valid_q <= rd_pend_q;
      if (rd_pend_q) begin
        rd_data_q <= ram_rdata;
      end else begin
        rd_data_q <= rd_data_q;
      end

      clr_done_q <= last_clr_d;

      case (state_q)
        ST_IDLE: begin
          if (clr_start) begin
            state_q    <= ST_CLEAR;
            cnt_q      <= {ADDR_W{1'b0}};
            clr_busy_q <= 1'b1;
          end else begin
            state_q    <= ST_IDLE;
            clr_busy_q <= 1'b0;
          end
        end
        ST_CLEAR: begin
          if (last_clr_d) begin
            state_q    <= ST_IDLE;
            cnt_q      <= {ADDR_W{1'b0}};
            clr_busy_q <= 1'b0;
          end else if (grant_clr_d) begin
            cnt_q      <= cnt_q + ADDR_W'(1'b1);
            clr_busy_q <= 1'b1;
          end else begin
            clr_busy_q <= 1'b1;
          end
        end
        default: begin
          state_q    <= ST_IDLE;
          cnt_q      <= {ADDR_W{1'b0}};
          clr_busy_q <= 1'b0;
        end
      endcase
    end
  end

  assign rd_ack    = rd_ack_q;
  assign rd_valid  = rd_valid_q;
  assign rd_data   = rd_data_q;
  assign mw_ack    = mw_ack_q;
  assign uw_ack    = uw_ack_q;
  assign clr_busy  = clr_busy_q;
  assign clr_done  = clr_done_q;
  assign ram_addr  = ram_addr_q;
  assign ram_wdata = ram_wdata_q;
  assign ram_we    = ram_we_q;
  assign ram_re    = ram_re_q;

endmodule
